// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/subtract engine: one DIGIT-bit ripple slice
// is reused for WIDTH/DIGIT cycles, LSB digit first, behind valid/ready handshakes.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_c,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] res_p0;
  logic             carry_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic             accept;
  logic             last_digit;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] res_nxt;

  function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  endfunction

  // Signed overflow: both operands share a sign that the sum does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign accept     = i_valid && (state == IDLE);
  assign last_digit = (cnt_p0 == CNT_W'(N - 1));

  // Operands shift right one digit per cycle, so the active digit always sits at
  // the bottom; the sum digit enters at the top of the result shift register.
  always_comb begin
    slice   = slice_add(a_p0[DIGIT-1:0], b_p0[DIGIT-1:0], carry_p0);
    res_nxt = (res_p0 >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (accept)             cnt_p0 <= '0;
      else if (state == BUSY) cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // ---- stage p0: operand capture and digit-serial accumulation ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_p0     <= i_a;
      b_p0     <= i_sub ? ~i_b : i_b;
      carry_p0 <= i_sub;
    end else if (state == BUSY) begin
      a_p0     <= a_p0 >> DIGIT;
      b_p0     <= b_p0 >> DIGIT;
      carry_p0 <= slice[DIGIT];
      res_p0   <= res_nxt;
    end
  end

  // ---- stage p1: result and flags, held until the next completion ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_c     <= '0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      o_zero  <= 1'b0;
    end else if ((state == BUSY) && last_digit) begin
      o_c     <= res_nxt;
      o_carry <= slice[DIGIT];
      o_ovf   <= signed_ovf(a_p0[DIGIT-1], b_p0[DIGIT-1], slice[DIGIT-1]);
      o_zero  <= (res_nxt == '0);
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed cases plus random operations on an 8-bit/2-bit
// instance and a 16-bit single-digit instance, against an arithmetic reference.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, or8, is8, ov8, ir8, ocy8, oov8, oz8;
  logic [7:0] ia8, ib8, oc8;

  logic        iv16, or16, is16, ov16, ir16, ocy16, oov16, oz16;
  logic [15:0] ia16, ib16, oc16;

  int checks = 0;
  int errors = 0;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv8), .o_ready(or8),
    .i_a(ia8), .i_b(ib8), .i_sub(is8), .o_valid(ov8), .i_ready(ir8),
    .o_c(oc8), .o_carry(ocy8), .o_ovf(oov8), .o_zero(oz8)
  );

  addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv16), .o_ready(or16),
    .i_a(ia16), .i_b(ib16), .i_sub(is16), .o_valid(ov16), .i_ready(ir16),
    .o_c(oc16), .o_carry(ocy16), .o_ovf(oov16), .o_zero(oz16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                           input bit sub, output logic [31:0] c, output logic [2:0] f);
    longint m, ua, ub, sa, sb, u, s;
    bit cy, ov;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    u  = sub ? ua - ub : ua + ub;
    s  = sub ? sa - sb : sa + sb;
    cy = sub ? (ua >= ub) : (u >= m);
    ov = (s >= m / 2) || (s < -(m / 2));
    c  = 32'(((u % m) + m) % m);
    f  = {cy, ov, (c == 32'd0)};
  endtask

  task automatic drive(input int w, input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit sub, input bit rdy);
    if (w == 8) begin
      iv8 = v; ia8 = a[7:0]; ib8 = b[7:0]; is8 = sub; ir8 = rdy;
    end else begin
      iv16 = v; ia16 = a[15:0]; ib16 = b[15:0]; is16 = sub; ir16 = rdy;
    end
  endtask

  function automatic logic [31:0] get_c(input int w);
    return (w == 8) ? {24'd0, oc8} : {16'd0, oc16};
  endfunction

  function automatic logic [31:0] get_f(input int w);
    return (w == 8) ? {29'd0, ocy8, oov8, oz8} : {29'd0, ocy16, oov16, oz16};
  endfunction

  function automatic logic [31:0] get_hs(input int w);
    return (w == 8) ? {30'd0, or8, ov8} : {30'd0, or16, ov16};
  endfunction

  // One complete transaction: accept, latency, result, optional stall, consume.
  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                    input bit sub, input int stall);
    logic [31:0] ec;
    logic [2:0]  ef;
    int n, t;
    n = (w == 8) ? 4 : 1;
    ref_model(w, a, b, sub, ec, ef);
    t = 0;
    while (get_hs(w) !== 32'b10 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("idle_before_accept_w%0d", w), get_hs(w), 32'b10);
    drive(w, 1'b1, a, b, sub, stall == 0);
    @(posedge clk); #1;
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom), stall == 0);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("latency_w%0d_k%0d", w, k), get_hs(w), (k == n) ? 32'b01 : 32'b00);
    end
    chk($sformatf("result_w%0d a=%0h b=%0h sub=%0d", w, a, b, sub), get_c(w), ec);
    chk($sformatf("flags_w%0d a=%0h b=%0h sub=%0d", w, a, b, sub), get_f(w), 32'(ef));
    for (int s = 0; s < stall; s++) begin
      drive(w, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
      @(posedge clk); #1;
      chk($sformatf("stall_hs_w%0d", w), get_hs(w), 32'b01);
      chk($sformatf("stall_result_w%0d", w), get_c(w), ec);
      chk($sformatf("stall_flags_w%0d", w), get_f(w), 32'(ef));
    end
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom), 1'b1);
    @(posedge clk); #1;
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom), 1'b0);
    chk($sformatf("consumed_hs_w%0d", w), get_hs(w), 32'b10);
    chk($sformatf("held_result_w%0d", w), get_c(w), ec);
    chk($sformatf("held_flags_w%0d", w), get_f(w), 32'(ef));
  endtask

  initial begin
    rst = 1'b1;
    drive(8, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(16, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hs_w8", get_hs(8), 32'b10);
    chk("reset_c_w8", get_c(8), 32'd0);
    chk("reset_f_w8", get_f(8), 32'd0);
    chk("reset_hs_w16", get_hs(16), 32'b10);
    chk("reset_c_w16", get_c(16), 32'd0);
    chk("reset_f_w16", get_f(16), 32'd0);
    rst = 1'b0;

    op(8, 32'h64, 32'h38, 1'b0, 0);
    chk("tp_add_c", get_c(8), 32'h9C);
    chk("tp_add_f", get_f(8), 32'b010);
    op(8, 32'hC8, 32'h38, 1'b1, 0);
    chk("tp_sub_c", get_c(8), 32'h90);
    chk("tp_sub_f", get_f(8), 32'b100);
    op(8, 32'h05, 32'h07, 1'b1, 0);
    chk("tp_borrow_c", get_c(8), 32'hFE);
    chk("tp_borrow_f", get_f(8), 32'b000);
    op(8, 32'h80, 32'h80, 1'b1, 0);
    chk("tp_sub_eq_c", get_c(8), 32'h00);
    chk("tp_sub_eq_f", get_f(8), 32'b101);
    op(8, 32'hFF, 32'h01, 1'b0, 5);
    chk("tp_add_wrap_c", get_c(8), 32'h00);
    chk("tp_add_wrap_f", get_f(8), 32'b101);

    // Reset lands on the second BUSY cycle; the operation must vanish.
    drive(8, 1'b1, 32'h11, 32'h22, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 32'h33, 32'h44, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_hs", get_hs(8), 32'b10);
    chk("midrst_c", get_c(8), 32'd0);
    chk("midrst_f", get_f(8), 32'd0);
    drive(8, 1'b0, 0, 0, 1'b0, 1'b0);
    op(8, 32'h7F, 32'h01, 1'b0, 0);

    op(16, 32'h7FFF, 32'h0001, 1'b0, 0);
    chk("n1_ovf_c", get_c(16), 32'h8000);
    chk("n1_ovf_f", get_f(16), 32'b010);
    op(16, 32'h0000, 32'h0001, 1'b1, 2);

    for (int i = 0; i < 300; i++)
      op(8, $urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    for (int i = 0; i < 200; i++)
      op(16, $urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
